decoder_bcd2to4_seq: RTL and testbench

Sequenced binary-to-one-hot decoder. It is the receive-side counterpart of the team's 4-to-2 encoder: it takes IN_W-bit codes over a valid/ready handshake, buffers them in a 2-entry FIFO, and presents each as a registered one-hot word. A scan mode cycles the one-hot output autonomously, for driving display/keypad strobe lines. It sits between a code producer (encoder, controller) and one-hot select/strobe consumers.

---
 rtl/decoder_bcd2to4_seq.sv | 131 +++++++++++++
 tb/tb_decoder_bcd2to4_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_bcd2to4_seq.sv
// rtl/decoder_bcd2to4_seq.sv - sequenced binary-to-one-hot decoder with 2-entry FIFO and scan mode
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   scan_en  request autonomous scan of the one-hot output
//   i        IN_W-bit code to decode
//   i_valid  i is valid this cycle
//   i_ready  block accepts i this cycle
//   o        OUT_W-bit one-hot word (all-zero when o_valid=0)
//   o_valid  o holds a decoded word
//   o_ready  consumer takes o this cycle (ignored while scanning)

module decoder_bcd2to4_seq #(
  parameter  int IN_W  = 2,
  parameter  int DWELL = 4,
  localparam int OUT_W = 2 ** IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  input  logic [IN_W-1:0]  i,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [OUT_W-1:0] o,
  output logic             o_valid,
  input  logic             o_ready
);

  typedef enum logic {NORM, SCAN} state_t;

  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
  localparam logic [OUT_W-1:0] ONE_HOT0   = OUT_W'(1);

  state_t          state;
  logic [IN_W-1:0] mem [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic [IN_W-1:0] scan_cnt;
  logic [7:0]      dwell_cnt;

  logic            push;
  logic            pop;
  logic [1:0]      nxt_count;
  logic [IN_W-1:0] nxt_head;
  logic [IN_W-1:0] scan_nxt;

  // i_ready depends only on reset, state and occupancy, never on o_ready,
  // so a pop in a full cycle re-opens the input only on the next cycle.
  assign i_ready  = !rst && (state == NORM) && (count != 2'd2);
  assign push     = i_valid && i_ready;
  // o_valid mirrors "FIFO not empty" in NORM, so it qualifies the pop.
  assign pop      = (state == NORM) && o_valid && o_ready;
  assign scan_nxt = scan_cnt + 1'b1;

  // Occupancy and head code as they will be after this edge; the output
  // register is loaded from these so a word is shown the cycle after it
  // is accepted into an empty FIFO.
  always_comb begin
    nxt_count = count;
    nxt_head  = mem[rd_ptr];
    case ({push, pop})
      2'b10:   nxt_count = count + 2'd1;
      2'b01:   nxt_count = count - 2'd1;
      default: nxt_count = count;
    endcase
    if (pop) begin
      // Second entry becomes head; with only one entry the head is the
      // code pushed this cycle (if none, nxt_count is 0 and it is unused).
      nxt_head = (count == 2'd2) ? mem[~rd_ptr] : i;
    end else if (count == 2'd0) begin
      nxt_head = i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= NORM;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      scan_cnt  <= '0;
      dwell_cnt <= 8'd0;
      o         <= '0;
      o_valid   <= 1'b0;
    end else begin
      case (state)
        NORM: begin
          if (push) begin
            mem[wr_ptr] <= i;
            wr_ptr      <= ~wr_ptr;
          end
          if (pop) begin
            rd_ptr <= ~rd_ptr;
          end
          count <= nxt_count;
          // Scan is only entered from an empty, idle FIFO; pending codes
          // are always delivered first.
          if (scan_en && (count == 2'd0) && !push) begin
            state     <= SCAN;
            scan_cnt  <= '0;
            dwell_cnt <= 8'd0;
            o         <= ONE_HOT0;
            o_valid   <= 1'b1;
          end else begin
            o_valid <= (nxt_count != 2'd0);
            o       <= (nxt_count != 2'd0) ? (ONE_HOT0 << nxt_head) : '0;
          end
        end
        SCAN: begin
          if (!scan_en) begin
            state   <= NORM;
            o       <= '0;
            o_valid <= 1'b0;
          end else if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= 8'd0;
            scan_cnt  <= scan_nxt;
            o         <= ONE_HOT0 << scan_nxt;
          end else begin
            dwell_cnt <= dwell_cnt + 8'd1;
          end
        end
        default: begin
          state <= NORM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_bcd2to4_seq.sv
// tb/tb_decoder_bcd2to4_seq.sv - scoreboard bench for decoder_bcd2to4_seq

module tb_decoder_bcd2to4_seq;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_en = 1'b0;
  logic [1:0] i = 2'd0;
  logic       i_valid = 1'b0;
  logic       i_ready;
  logic [3:0] o;
  logic       o_valid;
  logic       o_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  bit mon_en   = 1'b1;
  bit rnd_done = 1'b0;

  decoder_bcd2to4_seq #(.IN_W(2), .DWELL(DWELL)) dut (
    .clk     (clk),
    .rst     (rst),
    .scan_en (scan_en),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o       (o),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input int code);
    return 32'(2 ** code);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int code);
    bit ok = 1'b0;
    bit rdy;
    i       = 2'(code);
    i_valid = 1'b1;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      rdy = i_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(code);
        ok = 1'b1;
      end
    end
    #1;
    i_valid = 1'b0;
    check("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    o_ready = 1'b1;
    while (exp_q.size() != 0 && t < 64) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_scan(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check("scan_o", 32'(o), word_of((k / DWELL) % 4));
      check("scan_o_valid", 32'(o_valid), 32'd1);
      check("scan_i_ready", 32'(i_ready), 32'd0);
    end
  endtask

  // Monitor: compares the DUT against the queue of accepted codes while in
  // handshake mode; a transfer happens at the next edge when o_ready is high.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        check("i_ready_in_reset", 32'(i_ready), 32'd0);
      end else begin
        check("i_ready", 32'(i_ready), 32'(exp_q.size() < 2));
        check("o_valid", 32'(o_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          check("o_word", 32'(o), word_of(exp_q[0]));
          if (o_ready) void'(exp_q.pop_front());
        end else begin
          check("o_idle_zero", 32'(o), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    rst = 1'b0;
    idle(2);

    // 1: back-to-back pushes with consumer ready
    o_ready = 1'b1;
    for (int c = 0; c < 4; c++) push(c);
    idle(3);

    // 2: stalled consumer fills the FIFO, third push waits for a pop
    o_ready = 1'b0;
    push(2);
    push(1);
    fork
      push(3);
      begin
        idle(3);
        o_ready = 1'b1;
      end
    join
    drain();
    idle(2);

    // 3: steady push+pop at occupancy 1
    o_ready = 1'b0;
    push(0);
    o_ready = 1'b1;
    for (int n = 0; n < 6; n++) push(3);
    drain();
    idle(2);

    // 4: scan from empty FIFO, then exit
    scan_en = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    check_scan(20);
    scan_en = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle(2);

    // 5: scan requested while two codes are queued
    o_ready = 1'b0;
    push(1);
    push(2);
    scan_en = 1'b1;
    o_ready = 1'b1;
    for (int t = 0; t < 64 && exp_q.size() != 0; t++) @(posedge clk);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    check_scan(2 * DWELL);
    scan_en = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle(2);

    // 6a: reset while full and stalled
    o_ready = 1'b0;
    push(1);
    push(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    idle(2);
    o_ready = 1'b1;
    push(3);
    drain();
    idle(2);

    // 6b: reset mid-scan
    scan_en = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    idle(5);
    rst = 1'b1;
    scan_en = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Randomized traffic with a randomly stalling consumer
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          if ($urandom_range(2, 0) != 0) push(int'($urandom_range(3, 0)));
          else idle(1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          o_ready = 1'($urandom_range(1, 0));
        end
      end
    join
    drain();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
